// File: rtl/i_ref_setup_ramp.sv
// i_ref_setup_ramp
//   Setup sequencer for the reference current code. A start pulse loads full
//   scale and ramps the code down one step at a time. Each step settles for
//   SETTLE_CYCLES clocks and then samples the comparator. A trip freezes the
//   code and raises completed. Reaching the floor without a trip raises fail.
//
//   Optional build macro SETUP_RAMP_COARSE_EN adds a coarse search phase
//   ahead of the fine ramp.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active high
//   start        single-cycle request to (re)start the ramp
//   cmp_trip     comparator result, 1 = target reached (synchronous to clk)
//   i_ref_setup  current setup code (registered)
//   completed    setup succeeded, code frozen (registered)
//   fail         floor reached without a trip (registered)
//   busy         ramp in progress (registered)
//
// State   | meaning
// --------+------------------------------------------------------------
// IDLE    | out of reset, waiting for start
// SETTLE  | code applied, waiting SETTLE_CYCLES clocks for the analog node
// CHECK   | one cycle; comparator sampled at the edge that ends it
// DONE    | trip seen, code frozen, completed=1 until start or rst
// FAIL    | floor reached without trip, fail=1 until start or rst

module i_ref_setup_ramp #(
   parameter int BUS_WIDTH     = 10,
   parameter int STEP          = 1,
   parameter int SETTLE_CYCLES = 4,
   parameter int I_REF_MIN     = 0,
   parameter int COARSE_STEP   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 cmp_trip,
   output logic [BUS_WIDTH-1:0] i_ref_setup,
   output logic                 completed,
   output logic                 fail,
   output logic                 busy
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [BUS_WIDTH-1:0] CODE_MAX   = '1;
   localparam logic [BUS_WIDTH-1:0] STEP_W     = BUS_WIDTH'(STEP);
   // one extra bit so a floor above full scale still compares correctly
   localparam logic [BUS_WIDTH:0]   FINE_FLOOR = (BUS_WIDTH+1)'(I_REF_MIN + STEP);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_CHECK,
      S_DONE,
      S_FAIL
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] settle_cnt;

`ifdef SETUP_RAMP_COARSE_EN
   localparam logic [BUS_WIDTH-1:0] COARSE_W     = BUS_WIDTH'(COARSE_STEP);
   localparam logic [BUS_WIDTH:0]   COARSE_FLOOR = (BUS_WIDTH+1)'(I_REF_MIN + COARSE_STEP);

   logic                 phase_fine;
   logic [BUS_WIDTH:0]   coarse_up;
   logic [BUS_WIDTH-1:0] coarse_up_sat;

   // back off one coarse step after a trip, saturating at full scale
   always_comb begin
      coarse_up     = {1'b0, i_ref_setup} + {1'b0, COARSE_W};
      coarse_up_sat = coarse_up[BUS_WIDTH-1:0];
      if (coarse_up > {1'b0, CODE_MAX}) begin
         coarse_up_sat = CODE_MAX;
      end
   end
`else
   logic [BUS_WIDTH-1:0] unused_coarse_step;
   assign unused_coarse_step = BUS_WIDTH'(COARSE_STEP);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         settle_cnt  <= '0;
         i_ref_setup <= CODE_MAX;
         completed   <= 1'b0;
         fail        <= 1'b0;
         busy        <= 1'b0;
`ifdef SETUP_RAMP_COARSE_EN
         phase_fine  <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE, S_DONE, S_FAIL: begin
               if (start) begin
                  i_ref_setup <= CODE_MAX;
                  completed   <= 1'b0;
                  fail        <= 1'b0;
                  busy        <= 1'b1;
                  settle_cnt  <= '0;
                  state       <= S_SETTLE;
`ifdef SETUP_RAMP_COARSE_EN
                  phase_fine  <= 1'b0;
`endif
               end
            end
            S_SETTLE: begin
               if (settle_cnt == CNT_LAST) begin
                  settle_cnt <= '0;
                  state      <= S_CHECK;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            S_CHECK: begin
`ifdef SETUP_RAMP_COARSE_EN
               if (!phase_fine) begin
                  if (cmp_trip) begin
                     i_ref_setup <= coarse_up_sat;
                     phase_fine  <= 1'b1;
                  end else if ({1'b0, i_ref_setup} >= COARSE_FLOOR) begin
                     i_ref_setup <= i_ref_setup - COARSE_W;
                  end else begin
                     phase_fine  <= 1'b1;
                  end
                  state <= S_SETTLE;
               end else
`endif
               begin
                  if (cmp_trip) begin
                     completed <= 1'b1;
                     busy      <= 1'b0;
                     state     <= S_DONE;
                  end else if ({1'b0, i_ref_setup} >= FINE_FLOOR) begin
                     i_ref_setup <= i_ref_setup - STEP_W;
                     state       <= S_SETTLE;
                  end else begin
                     fail  <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_FAIL;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
